// File: rtl/hs32_aic_pkg.sv
// Shared constants for the hs32 interrupt controller: line count, register offsets, FSM states.
// Optional priority arbitration is enabled with `define HS32_AIC_PRIORITY_EN.
package hs32_aic_pkg;

  localparam int NLINES = 24;

  localparam logic [6:0] HT_BASE    = 7'h00;
  localparam logic [6:0] EN_OFF     = 7'h60;
  localparam logic [6:0] PEND_OFF   = 7'h64;
  localparam logic [6:0] PRI_LO_OFF = 7'h68;
  localparam logic [6:0] PRI_HI_OFF = 7'h6C;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  function automatic logic [NLINES-1:0] onehot(input logic [4:0] idx);
    onehot = {{(NLINES-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/hs32_aic_prio.sv
// Combinational arbiter: picks the winning eligible line; line 0 always wins.
// With HS32_AIC_PRIORITY_EN the highest 2-bit PRI wins (ties to lowest index), else lowest index.
module hs32_aic_prio
  import hs32_aic_pkg::*;
(
  input  logic [NLINES-1:0]   eligible,
  input  logic [2*NLINES-1:0] pri,
  output logic                found,
  output logic [4:0]          idx
);

`ifdef HS32_AIC_PRIORITY_EN
  logic [1:0] best_s;
  logic       have_s;

  // Highest priority among lines 1..N-1, strict compare keeps the lowest index on ties
  always_comb begin
    found  = |eligible;
    idx    = 5'd0;
    best_s = 2'd0;
    have_s = 1'b0;
    for (int i = 1; i < NLINES; i++) begin
      if (eligible[i] && (!have_s || (pri[2*i +: 2] > best_s))) begin
        have_s = 1'b1;
        best_s = pri[2*i +: 2];
        idx    = 5'(i);
      end else begin
      end
    end
    if (eligible[0]) begin
      idx = 5'd0;
    end else begin
    end
  end
`else
  logic unused_pri_s;
  assign unused_pri_s = ^pri;

  // Lowest eligible index wins, which also makes line 0 unbeatable
  always_comb begin
    found = |eligible;
    idx   = 5'd0;
    for (int i = NLINES - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        idx = 5'(i);
      end else begin
      end
    end
  end
`endif

endmodule

// File: rtl/hs32_aic.sv
// hs32 interrupt controller: edge-triggered pending bits, handler table, mask, single-request FSM.
// Define HS32_AIC_PRIORITY_EN to add per-line 2-bit priorities at 0x68/0x6C.
module hs32_aic
  import hs32_aic_pkg::*;
#(
  parameter int NLINES = hs32_aic_pkg::NLINES
) (
  input  logic              i_clk,
  input  logic              reset,
  input  logic [NLINES-1:0] interrupts,
  input  logic              stb,
  output logic              ack,
  input  logic              rw,
  input  logic [6:0]        addr,
  input  logic [31:0]       dtw,
  output logic [31:0]       dtr,
  output logic [31:0]       handler,
  output logic              intrq,
  output logic [4:0]        vec,
  output logic              nmi,
  input  logic              iack
);

  logic [NLINES-1:0]   irq_q_r;
  logic [NLINES-1:0]   pending_r;
  logic [NLINES-1:0]   en_r;
  logic [31:0]         ht_r [NLINES];
  logic [2*NLINES-1:0] pri_s;
  state_t              state_r;

  logic [NLINES-1:0] rise_s;
  logic [NLINES-1:0] clr_s;
  logic [NLINES-1:0] eligible_s;
  logic [6:0]        reg_off_s;
  logic [6:0]        ht_off_s;
  logic [4:0]        ht_idx_s;
  logic              ht_hit_s;
  logic              wr_s;
  logic [31:0]       rd_s;
  logic              found_s;
  logic [4:0]        win_s;
  logic              unused_addr_s;

  assign reg_off_s     = {addr[6:2], 2'b00};
  assign unused_addr_s = ^addr[1:0];
  assign ht_off_s      = reg_off_s - HT_BASE;
  assign ht_hit_s      = ht_off_s < 7'(4 * NLINES);
  assign ht_idx_s      = ht_off_s[6:2];
  assign wr_s          = stb & rw;

  // A new edge always beats a clear in the same cycle, whether from the bus or from iack
  assign rise_s     = interrupts & ~irq_q_r;
  assign clr_s      = (((wr_s && (reg_off_s == PEND_OFF)) ? dtw[NLINES-1:0] : {NLINES{1'b0}})
                    | (((state_r == REQ) && iack) ? onehot(vec) : {NLINES{1'b0}}));
  assign eligible_s = pending_r & (en_r | onehot(5'd0));

`ifdef HS32_AIC_PRIORITY_EN
  logic [2*NLINES-1:0] pri_r;
  assign pri_s = pri_r;
`else
  assign pri_s = {(2*NLINES){1'b0}};
`endif

  hs32_aic_prio u_prio (
    .eligible (eligible_s),
    .pri      (pri_s),
    .found    (found_s),
    .idx      (win_s)
  );

  // Register read mux; unmapped offsets read as zero
  always_comb begin
    rd_s = 32'd0;
    if (ht_hit_s) begin
      rd_s = ht_r[ht_idx_s];
    end else if (reg_off_s == EN_OFF) begin
      rd_s = {{(32-NLINES){1'b0}}, en_r};
    end else if (reg_off_s == PEND_OFF) begin
      rd_s = {{(32-NLINES){1'b0}}, pending_r};
`ifdef HS32_AIC_PRIORITY_EN
    end else if (reg_off_s == PRI_LO_OFF) begin
      rd_s = {{(32-NLINES){1'b0}}, pri_r[NLINES-1:0]};
    end else if (reg_off_s == PRI_HI_OFF) begin
      rd_s = {{(32-NLINES){1'b0}}, pri_r[2*NLINES-1:NLINES]};
`endif
    end else begin
      rd_s = 32'd0;
    end
  end

  // Bus registers, edge detector and pending bits
  always_ff @(posedge i_clk) begin
    if (reset) begin
      ack       <= 1'b0;
      dtr       <= 32'd0;
      irq_q_r   <= {NLINES{1'b0}};
      pending_r <= {NLINES{1'b0}};
      en_r      <= {NLINES{1'b0}};
      for (int i = 0; i < NLINES; i++) begin
        ht_r[i] <= 32'd0;
      end
`ifdef HS32_AIC_PRIORITY_EN
      pri_r <= {(2*NLINES){1'b0}};
`endif
    end else begin
      irq_q_r   <= interrupts;
      pending_r <= (pending_r & ~clr_s) | rise_s;
      ack       <= stb;
      if (stb) begin
        dtr <= rd_s;
      end
      if (wr_s) begin
        if (ht_hit_s) begin
          ht_r[ht_idx_s] <= dtw;
        end
        if (reg_off_s == EN_OFF) begin
          en_r <= dtw[NLINES-1:0];
        end
`ifdef HS32_AIC_PRIORITY_EN
        if (reg_off_s == PRI_LO_OFF) begin
          pri_r[NLINES-1:0] <= dtw[NLINES-1:0];
        end
        if (reg_off_s == PRI_HI_OFF) begin
          pri_r[2*NLINES-1:NLINES] <= dtw[NLINES-1:0];
        end
`endif
      end
    end
  end

  // Request FSM: outputs are frozen in REQ until the CPU acknowledges
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_r <= IDLE;
      intrq   <= 1'b0;
      vec     <= 5'd0;
      handler <= 32'd0;
      nmi     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (found_s) begin
            state_r <= REQ;
            intrq   <= 1'b1;
            vec     <= win_s;
            handler <= ht_r[win_s];
            nmi     <= (win_s == 5'd0);
          end
        end
        REQ: begin
          if (iack) begin
            state_r <= IDLE;
            intrq   <= 1'b0;
            nmi     <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          intrq   <= 1'b0;
          nmi     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs32_aic.sv
// Self-checking bench for hs32_aic: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_hs32_aic;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] interrupts;
  logic        stb, rw, iack;
  logic [6:0]  addr;
  logic [31:0] dtw;
  logic        ack, intrq, nmi;
  logic [31:0] dtr, handler;
  logic [4:0]  vec;

  always #5 clk = ~clk;

  hs32_aic dut (
    .i_clk      (clk),
    .reset      (reset),
    .interrupts (interrupts),
    .stb        (stb),
    .ack        (ack),
    .rw         (rw),
    .addr       (addr),
    .dtw        (dtw),
    .dtr        (dtr),
    .handler    (handler),
    .intrq      (intrq),
    .vec        (vec),
    .nmi        (nmi),
    .iack       (iack)
  );

`ifdef HS32_AIC_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [23:0] m_pend, m_en, m_prev;
  logic [1:0]  m_pri [24];
  logic [31:0] m_ht  [24];
  logic        m_intrq, m_nmi, m_ack;
  logic [4:0]  m_vec;
  logic [31:0] m_handler, m_dtr;

  function automatic int pick();
    bit el [24];
    for (int i = 0; i < 24; i++) el[i] = m_pend[i] && (m_en[i] || i == 0);
    if (el[0]) return 0;
    if (PRIO) begin
      for (int lvl = 3; lvl >= 0; lvl--)
        for (int i = 1; i < 24; i++)
          if (el[i] && int'(m_pri[i]) == lvl) return i;
    end else begin
      for (int i = 1; i < 24; i++) if (el[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [31:0] mread(input logic [6:0] a);
    int w;
    logic [31:0] r;
    w = int'(a[6:2]);
    r = 32'd0;
    if (w < 24) r = m_ht[w];
    else if (w == 24) r = {8'h00, m_en};
    else if (w == 25) r = {8'h00, m_pend};
    else if (PRIO && (w == 26 || w == 27))
      for (int i = 0; i < 12; i++) r[2*i +: 2] = m_pri[(w - 26) * 12 + i];
    return r;
  endfunction

  task automatic model_step();
    logic [31:0] rd;
    logic [23:0] np;
    int w, win;
    bit rise, clr;
    if (reset) begin
      m_pend = 24'd0; m_en = 24'd0; m_prev = 24'd0;
      for (int i = 0; i < 24; i++) begin m_pri[i] = 2'd0; m_ht[i] = 32'd0; end
      m_intrq = 1'b0; m_nmi = 1'b0; m_ack = 1'b0;
      m_vec = 5'd0; m_handler = 32'd0; m_dtr = 32'd0;
      return;
    end
    rd = mread(addr);
    w  = int'(addr[6:2]);
    for (int i = 0; i < 24; i++) begin
      rise  = interrupts[i] && !m_prev[i];
      clr   = (stb && rw && w == 25 && dtw[i]) || (m_intrq && iack && i == int'(m_vec));
      np[i] = rise ? 1'b1 : (clr ? 1'b0 : m_pend[i]);
    end
    if (!m_intrq) begin
      win = pick();
      if (win >= 0) begin
        m_intrq = 1'b1; m_vec = 5'(win); m_handler = m_ht[win]; m_nmi = (win == 0);
      end
    end else if (iack) begin
      m_intrq = 1'b0; m_nmi = 1'b0;
    end
    m_ack = stb;
    if (stb) m_dtr = rd;
    if (stb && rw) begin
      if (w < 24) m_ht[w] = dtw;
      else if (w == 24) m_en = dtw[23:0];
      else if (PRIO && (w == 26 || w == 27))
        for (int i = 0; i < 12; i++) m_pri[(w - 26) * 12 + i] = dtw[2*i +: 2];
    end
    m_pend = np;
    m_prev = interrupts;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("intrq", 32'(intrq), 32'(m_intrq));
      check("nmi", 32'(nmi), 32'(m_nmi));
      check("ack", 32'(ack), 32'(m_ack));
      if (m_intrq) begin
        check("vec", 32'(vec), 32'(m_vec));
        check("handler", handler, m_handler);
      end
      if (m_ack) check("dtr", dtr, m_dtr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [6:0] a, input logic [31:0] d);
    stb = 1'b1; rw = 1'b1; addr = a; dtw = d;
    step();
    check("wr_ack", 32'(ack), 32'd1);
    stb = 1'b0; rw = 1'b0;
  endtask

  task automatic bus_read(input logic [6:0] a, output logic [31:0] d);
    stb = 1'b1; rw = 1'b0; addr = a;
    step();
    check("rd_ack", 32'(ack), 32'd1);
    d = dtr;
    stb = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    reset = 1'b1; interrupts = 24'd0; stb = 1'b0; rw = 1'b0;
    addr = 7'd0; dtw = 32'd0; iack = 1'b0;
    step(); step();
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_intrq", 32'(intrq), 32'd0);
    check("rst_handler", handler, 32'd0);
    check("rst_vec", 32'(vec), 32'd0);
    check("rst_nmi", 32'(nmi), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_dtr", dtr, 32'd0);

    // Basic maskable request on line 5
    bus_write(7'h14, 32'h0000_1000);
    bus_write(7'h60, 32'h0000_0020);
    interrupts = 24'h20;
    step(); step();
    check("l5_intrq", 32'(intrq), 32'd1);
    check("l5_vec", 32'(vec), 32'd5);
    check("l5_handler", handler, 32'h0000_1000);
    check("l5_nmi", 32'(nmi), 32'd0);
    interrupts = 24'd0; iack = 1'b1;
    step();
    iack = 1'b0;
    check("l5_drop", 32'(intrq), 32'd0);
    bus_read(7'h64, d);
    check("l5_pend_clr", d, 32'd0);

    // Non-maskable line 0, masked line 7
    bus_write(7'h60, 32'd0);
    interrupts = 24'h1;
    step(); step();
    check("nmi_intrq", 32'(intrq), 32'd1);
    check("nmi_vec", 32'(vec), 32'd0);
    check("nmi_flag", 32'(nmi), 32'd1);
    interrupts = 24'd0; iack = 1'b1;
    step();
    iack = 1'b0;
    check("nmi_drop", 32'(nmi), 32'd0);
    interrupts = 24'h80;
    step(); step(); step();
    check("masked_l7", 32'(intrq), 32'd0);
    interrupts = 24'd0;
    bus_write(7'h64, 32'h0000_0080);

    // Two lines pending together, priorities 3 (line 9) vs 1 (line 3)
    bus_write(7'h60, 32'h0000_0208);
    bus_write(7'h68, 32'h000C_0040);
    interrupts = 24'h208;
    step(); step();
    check("pri_first", 32'(vec), PRIO ? 32'd9 : 32'd3);
    interrupts = 24'd0; iack = 1'b1;
    step();
    iack = 1'b0;
    check("pri_gap", 32'(intrq), 32'd0);
    step();
    check("pri_second_rq", 32'(intrq), 32'd1);
    check("pri_second", 32'(vec), PRIO ? 32'd3 : 32'd9);
    iack = 1'b1;
    step();
    iack = 1'b0;

    // New edge on the granted line during iack re-requests after the gap
    bus_write(7'h10, 32'h0000_4444);
    bus_write(7'h60, 32'h0000_0010);
    interrupts = 24'h10;
    step(); step();
    check("l4_vec", 32'(vec), 32'd4);
    check("l4_handler", handler, 32'h0000_4444);
    interrupts = 24'd0;
    step();
    interrupts = 24'h10; iack = 1'b1;
    step();
    iack = 1'b0;
    check("l4_drop", 32'(intrq), 32'd0);
    step();
    check("l4_rearm", 32'(intrq), 32'd1);
    check("l4_rearm_vec", 32'(vec), 32'd4);

    // Bus clear of the granted pending bit does not withdraw the request
    bus_write(7'h64, 32'h0000_0010);
    check("w1c_hold", 32'(intrq), 32'd1);
    bus_read(7'h64, d);
    check("w1c_bit4", 32'(d[4]), 32'd0);
    check("w1c_hold2", 32'(intrq), 32'd1);

    // Reset during REQ, with a strobe in the reset cycle
    interrupts = 24'd0; reset = 1'b1; stb = 1'b1; rw = 1'b0; addr = 7'h60;
    step();
    reset = 1'b0; stb = 1'b0;
    check("rreq_intrq", 32'(intrq), 32'd0);
    check("rreq_handler", handler, 32'd0);
    step();
    check("rreq_noack", 32'(ack), 32'd0);
    bus_read(7'h60, d);
    check("rreq_en", d, 32'd0);
    step(); step();
    check("rreq_idle", 32'(intrq), 32'd0);

    // Register map boundaries
    bus_write(7'h5C, 32'hDEAD_BEEF);
    bus_read(7'h5F, d);
    check("ht23", d, 32'hDEAD_BEEF);
    bus_write(7'h70, 32'hFFFF_FFFF);
    bus_read(7'h70, d);
    check("unmapped", d, 32'd0);
    bus_write(7'h68, 32'hFFAB_CDEF);
    bus_read(7'h68, d);
    check("pri_lo_rd", d, PRIO ? 32'h00AB_CDEF : 32'd0);

    // Randomized traffic, checked each cycle by the model
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 3) == 0) interrupts = interrupts ^ (24'd1 << $urandom_range(0, 23));
      stb  = ($urandom_range(0, 9) < 4);
      rw   = 1'($urandom_range(0, 1));
      addr = 7'($urandom_range(0, 127));
      dtw  = $urandom;
      iack = m_intrq ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      step();
    end
    reset = 1'b0; stb = 1'b0; iack = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
